// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Round-robin scheduler that shares one UART transmitter between NUM_REQ
//   status requesters. Each grant becomes a 4-byte frame
//   (header, source id, data, xor checksum), pushed one byte at a time and
//   paced on the transmitter's busy output.
//
// Ports
//   clk          rising-edge system clock
//   rst_n        synchronous active-low reset
//   req_valid    per-requester pending flag (level, held until acked)
//   req_data     status bytes, requester i on [8i+7:8i]
//   req_ack      one-cycle grant pulse; req_data captured that cycle
//   tx_start     one-cycle start pulse to the transmitter
//   tx_data      byte to the transmitter, held between loads
//   tx_busy      transmitter busy
//   frame_active high from grant until frame completes or aborts
//   cur_src      id of the requester being served
//   err_timeout  sticky: tx_busy failed to rise within BUSY_TIMEOUT cycles
//   err_clr      clears err_timeout
module uart_tx_scheduler #(
  parameter int          NUM_REQ      = 4,
  parameter logic [7:0]  HEADER_BYTE  = 8'hA5,
  parameter int          BUSY_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 frame_active,
  output logic [2:0]           cur_src,
  output logic                 err_timeout,
  input  logic                 err_clr
);

  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t        state_q, state_d;
  logic [2:0]    rr_ptr_q, rr_ptr_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic [2:0]    cur_src_q, cur_src_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          err_q, err_d;
  logic          frame_active_q, frame_active_d;

  logic [7:0]    valid_ext;
  logic [2:0]    scan_idx;
  logic          grant_found;
  logic [2:0]    grant_idx;
  logic [7:0]    data_sel;
  logic [7:0]    cur_byte;
  logic [7:0]    checksum;
  logic [2:0]    next_ptr;

  // Rotating priority scan: first pending requester at or above rr_ptr,
  // wrapping modulo NUM_REQ. valid_ext lets a 3-bit index address any width.
  always_comb begin
    valid_ext   = 8'(req_valid);
    scan_idx    = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = 3'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_found && valid_ext[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    data_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == 3'(i)) data_sel = req_data[8*i +: 8];
    end
  end

  always_comb begin
    checksum = HEADER_BYTE ^ {5'b0, cur_src_q} ^ data_q;
    case (byte_idx_q)
      2'd0:    cur_byte = HEADER_BYTE;
      2'd1:    cur_byte = {5'b0, cur_src_q};
      2'd2:    cur_byte = data_q;
      default: cur_byte = checksum;
    endcase
    next_ptr = 3'((int'(cur_src_q) + 1) % NUM_REQ);
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    byte_idx_d     = byte_idx_q;
    cnt_d          = cnt_q;
    data_d         = data_q;
    cur_src_d      = cur_src_q;
    tx_data_d      = tx_data_q;
    frame_active_d = frame_active_q;
    req_ack        = '0;
    tx_start       = 1'b0;
    // Clear first so that a same-cycle timeout below overrides it.
    err_d          = err_clr ? 1'b0 : err_q;

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          // The ack is suppressed while reset is asserted so no grant
          // escapes from a frame that is being dropped.
          for (int i = 0; i < NUM_REQ; i++) begin
            req_ack[i] = rst_n && (grant_idx == 3'(i));
          end
          data_d         = data_sel;
          cur_src_d      = grant_idx;
          byte_idx_d     = '0;
          frame_active_d = 1'b1;
          state_d        = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start  = 1'b1;
          tx_data_d = cur_byte;
          cnt_d     = '0;
          state_d   = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_d = WAIT_LO;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CW'(BUSY_TIMEOUT)) begin
            err_d          = 1'b1;
            frame_active_d = 1'b0;
            rr_ptr_d       = next_ptr;
            state_d        = IDLE;
          end
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (byte_idx_q == 2'd3) begin
            frame_active_d = 1'b0;
            rr_ptr_d       = next_ptr;
            state_d        = IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      byte_idx_q     <= '0;
      cnt_q          <= '0;
      data_q         <= '0;
      cur_src_q      <= '0;
      tx_data_q      <= '0;
      err_q          <= 1'b0;
      frame_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      byte_idx_q     <= byte_idx_d;
      cnt_q          <= cnt_d;
      data_q         <= data_d;
      cur_src_q      <= cur_src_d;
      tx_data_q      <= tx_data_d;
      err_q          <= err_d;
      frame_active_q <= frame_active_d;
    end
  end

  assign tx_data      = tx_data_d;
  assign frame_active = frame_active_q;
  assign cur_src      = cur_src_q;
  assign err_timeout  = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler
//   Directed bench for uart_tx_scheduler with a small UART transmitter model
//   that raises busy for busy_len cycles after each accepted tx_start.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ack;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        frame_active;
  logic [2:0]  cur_src;
  logic        err_timeout;
  logic        err_clr;

  logic        model_on;
  logic        model_busy;
  logic        force_busy;
  logic        pending;
  int          busy_len;
  int          busy_cnt;

  logic [7:0]  bytes_q[$];
  int          grant_log[$];
  int          ack_cnt[4];
  int          starts;
  int          s0;
  int          n;

  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign tx_busy = model_busy | force_busy;

  uart_tx_scheduler #(
    .NUM_REQ(4),
    .HEADER_BYTE(8'hA5),
    .BUSY_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ack(req_ack),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .frame_active(frame_active),
    .cur_src(cur_src),
    .err_timeout(err_timeout),
    .err_clr(err_clr)
  );

  // Records bytes and grants with the values present just before each edge.
  always @(posedge clk) begin
    if (tx_start) begin
      bytes_q.push_back(tx_data);
      starts++;
      if (model_on) pending = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      if (req_ack[i]) begin
        ack_cnt[i]++;
        grant_log.push_back(i);
      end
    end
  end

  // Transmitter model: busy rises half a cycle after the accepted start.
  always @(negedge clk) begin
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) model_busy = 1'b0;
    end
    if (pending) begin
      pending    = 1'b0;
      model_busy = 1'b1;
      busy_cnt   = busy_len;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int max_cycles, input string tag);
    int k;
    k = 0;
    while (frame_active !== 1'b0 && k < max_cycles) begin
      tick();
      k++;
    end
    check_output(tag, 32'(frame_active), 32'd0);
  endtask

  task automatic clear_acks();
    for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    err_clr    = 1'b0;
    model_on   = 1'b1;
    model_busy = 1'b0;
    force_busy = 1'b0;
    pending    = 1'b0;
    busy_len   = 20;
    busy_cnt   = 0;
    starts     = 0;
    clear_acks();

    // Reset state
    tick();
    tick();
    check_output("rst_req_ack", 32'(req_ack), 32'h0);
    check_output("rst_tx_start", 32'(tx_start), 32'h0);
    check_output("rst_tx_data", 32'(tx_data), 32'h0);
    check_output("rst_frame_active", 32'(frame_active), 32'h0);
    check_output("rst_cur_src", 32'(cur_src), 32'h0);
    check_output("rst_err", 32'(err_timeout), 32'h0);
    req_valid = 4'b0001;
    #1;
    check_output("rst_ack_gated", 32'(req_ack), 32'h0);
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // Single request from requester 2
    $display("[TB] single request");
    bytes_q.delete();
    clear_acks();
    req_valid = 4'b0100;
    req_data  = 32'h003C_0000;
    #1;
    check_output("t1_ack", 32'(req_ack), 32'h4);
    tick();
    req_valid = '0;
    check_output("t1_frame_active", 32'(frame_active), 32'h1);
    check_output("t1_cur_src", 32'(cur_src), 32'h2);
    check_output("t1_first_start", 32'(tx_start), 32'h1);
    check_output("t1_first_byte", 32'(tx_data), 32'hA5);
    check_output("t1_ack_pulse", 32'(req_ack), 32'h0);
    wait_idle(400, "t1_done");
    check_output("t1_nbytes", 32'(bytes_q.size()), 32'd4);
    check_output("t1_b0", 32'(bytes_q[0]), 32'hA5);
    check_output("t1_b1", 32'(bytes_q[1]), 32'h02);
    check_output("t1_b2", 32'(bytes_q[2]), 32'h3C);
    check_output("t1_b3", 32'(bytes_q[3]), 32'h9B);
    check_output("t1_ack_once", 32'(ack_cnt[2]), 32'd1);
    check_output("t1_tx_data_hold", 32'(tx_data), 32'h9B);

    // Transmitter already busy at grant time
    $display("[TB] starting busy");
    bytes_q.delete();
    force_busy = 1'b1;
    req_valid  = 4'b0001;
    req_data   = 32'h0000_0011;
    #1;
    check_output("t2_ack", 32'(req_ack), 32'h1);
    tick();
    req_valid = '0;
    check_output("t2_start_held", 32'(tx_start), 32'h0);
    check_output("t2_frame_active", 32'(frame_active), 32'h1);
    repeat (9) tick();
    check_output("t2_start_held_late", 32'(tx_start), 32'h0);
    force_busy = 1'b0;
    #1;
    check_output("t2_start_after_busy", 32'(tx_start), 32'h1);
    check_output("t2_first_byte", 32'(tx_data), 32'hA5);
    wait_idle(400, "t2_done");
    check_output("t2_nbytes", 32'(bytes_q.size()), 32'd4);
    check_output("t2_b1", 32'(bytes_q[1]), 32'h00);
    check_output("t2_b2", 32'(bytes_q[2]), 32'h11);
    check_output("t2_b3", 32'(bytes_q[3]), 32'hB4);

    // Fairness with all requesters pending
    $display("[TB] fairness");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    busy_len = 3;
    bytes_q.delete();
    grant_log.delete();
    clear_acks();
    req_valid = 4'b1111;
    req_data  = 32'h4433_2211;
    n = 0;
    while (grant_log.size() < 5 && n < 2000) begin
      tick();
      n++;
    end
    req_valid = '0;
    check_output("t3_ngrants", 32'(grant_log.size()), 32'd5);
    check_output("t3_g0", 32'(grant_log[0]), 32'd0);
    check_output("t3_g1", 32'(grant_log[1]), 32'd1);
    check_output("t3_g2", 32'(grant_log[2]), 32'd2);
    check_output("t3_g3", 32'(grant_log[3]), 32'd3);
    check_output("t3_g4_wrap", 32'(grant_log[4]), 32'd0);
    wait_idle(400, "t3_done");
    check_output("t3_f1_b1", 32'(bytes_q[5]), 32'h01);
    check_output("t3_f1_b2", 32'(bytes_q[6]), 32'h22);
    check_output("t3_f1_b3", 32'(bytes_q[7]), 32'h86);
    check_output("t3_ack0", 32'(ack_cnt[0]), 32'd2);
    check_output("t3_ack1", 32'(ack_cnt[1]), 32'd1);
    check_output("t3_ack2", 32'(ack_cnt[2]), 32'd1);
    check_output("t3_ack3", 32'(ack_cnt[3]), 32'd1);

    // Timeout: transmitter never raises busy
    $display("[TB] timeout");
    model_on  = 1'b0;
    s0        = starts;
    req_valid = 4'b0110;
    req_data  = 32'h0000_9900;
    #1;
    check_output("t4_ack", 32'(req_ack), 32'h2);
    tick();
    req_valid = 4'b0100;
    check_output("t4_start", 32'(tx_start), 32'h1);
    repeat (16) tick();
    check_output("t4_err_before", 32'(err_timeout), 32'h0);
    check_output("t4_active_before", 32'(frame_active), 32'h1);
    tick();
    check_output("t4_err_set", 32'(err_timeout), 32'h1);
    check_output("t4_aborted", 32'(frame_active), 32'h0);
    check_output("t4_next_req", 32'(req_ack), 32'h4);
    tick();
    req_valid = '0;
    err_clr   = 1'b1;
    check_output("t4_second_start", 32'(tx_start), 32'h1);
    tick();
    err_clr = 1'b0;
    check_output("t4_err_cleared", 32'(err_timeout), 32'h0);
    repeat (15) tick();
    err_clr = 1'b1;
    check_output("t4_active_second", 32'(frame_active), 32'h1);
    tick();
    err_clr = 1'b0;
    check_output("t4_set_wins", 32'(err_timeout), 32'h1);
    check_output("t4_aborted2", 32'(frame_active), 32'h0);
    check_output("t4_one_byte_each", 32'(starts - s0), 32'd2);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_output("t4_err_clr_final", 32'(err_timeout), 32'h0);

    // Reset during the WAIT_LO of byte 2
    $display("[TB] reset mid-frame");
    model_on = 1'b1;
    busy_len = 20;
    clear_acks();
    s0        = starts;
    req_valid = 4'b1000;
    req_data  = 32'h7700_0055;
    #1;
    check_output("t5_ack", 32'(req_ack), 32'h8);
    tick();
    req_valid = '0;
    n = 0;
    while (starts < s0 + 3 && n < 500) begin
      tick();
      n++;
    end
    repeat (5) tick();
    check_output("t5_in_frame", 32'(frame_active), 32'h1);
    rst_n      = 1'b0;
    force_busy = 1'b1;
    model_on   = 1'b0;
    pending    = 1'b0;
    busy_cnt   = 0;
    model_busy = 1'b0;
    tick();
    check_output("t5_rst_ack", 32'(req_ack), 32'h0);
    check_output("t5_rst_start", 32'(tx_start), 32'h0);
    check_output("t5_rst_tx_data", 32'(tx_data), 32'h0);
    check_output("t5_rst_active", 32'(frame_active), 32'h0);
    check_output("t5_rst_cur_src", 32'(cur_src), 32'h0);
    check_output("t5_rst_err", 32'(err_timeout), 32'h0);
    rst_n     = 1'b1;
    req_valid = 4'b1001;
    #1;
    check_output("t5_ptr_reset", 32'(req_ack), 32'h1);
    tick();
    req_valid = '0;
    check_output("t5_wait_busy", 32'(tx_start), 32'h0);
    check_output("t5_active", 32'(frame_active), 32'h1);
    repeat (3) tick();
    check_output("t5_wait_busy_late", 32'(tx_start), 32'h0);
    bytes_q.delete();
    model_on   = 1'b1;
    force_busy = 1'b0;
    #1;
    check_output("t5_start", 32'(tx_start), 32'h1);
    check_output("t5_first_byte", 32'(tx_data), 32'hA5);
    wait_idle(400, "t5_done");
    check_output("t5_nbytes", 32'(bytes_q.size()), 32'd4);
    check_output("t5_b1", 32'(bytes_q[1]), 32'h00);
    check_output("t5_b2", 32'(bytes_q[2]), 32'h55);
    check_output("t5_b3", 32'(bytes_q[3]), 32'hF0);
    check_output("t5_no_reack", 32'(ack_cnt[3]), 32'd1);
    check_output("t5_ack0", 32'(ack_cnt[0]), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Round-robin scheduler that shares the single UART transmitter between NUM_REQ status requesters, such as the sensor, door and appliance controllers. Each granted request becomes a fixed 4-byte frame: header, source id, data, checksum. The block drives the transmitter's tx_start/tx_data one byte at a time and paces itself on the transmitter's busy output. It sits between the home-control logic and the UART transmitter.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.
HEADER_BYTE, 8'hA5, first byte of every frame.
BUSY_TIMEOUT, 16, maximum cycles to wait for tx_busy to rise after a tx_start pulse.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst_n  input  1  synchronous, active-low reset.
req_valid  input  NUM_REQ  per-requester "status byte pending"; level, held until acked.
req_data  input  8*NUM_REQ  status bytes; requester i uses bits [8i+7:8i].
req_ack  output  NUM_REQ  one-cycle pulse on the granted bit; req_data is captured in that cycle.
tx_start  output  1  one-cycle start pulse to the UART transmitter.
tx_data  output  8  byte to the transmitter; valid while tx_start is high and held until the next load.
tx_busy  input  1  busy output of the UART transmitter.
frame_active  output  1  high from grant until the last byte completes or the frame aborts.
cur_src  output  3  id of the requester being served; zero-extended for small NUM_REQ.
err_timeout  output  1  sticky flag; set when tx_busy fails to rise within BUSY_TIMEOUT.
err_clr  input  1  clears err_timeout.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; req_ack=0, tx_start=0, tx_data=0, frame_active=0, cur_src=0, err_timeout=0, rr_ptr=0, byte_idx=0, timeout counter=0.
- Reset mid-frame: the frame is dropped; no ack is re-issued.
- States: IDLE, SEND, WAIT_HI, WAIT_LO.
- IDLE:
  - If any req_valid is high, grant the first set bit scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - Same cycle: pulse req_ack[w]; latch req_data[w] into data_reg; cur_src=w; byte_idx=0; frame_active=1; next state SEND.
  - If no req_valid is set, stay in IDLE.
- SEND:
  - If tx_busy=1, wait.
  - Otherwise drive tx_data = byte[byte_idx] with tx_start=1 for exactly one cycle; clear the timeout counter; go to WAIT_HI.
- Byte sequence:
  - byte 0 = HEADER_BYTE.
  - byte 1 = {5'b0, cur_src}.
  - byte 2 = data_reg.
  - byte 3 = byte0 ^ byte1 ^ byte2 (8-bit XOR).
- WAIT_HI:
  - tx_busy=1: go to WAIT_LO.
  - Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT: set err_timeout, frame_active=0, rr_ptr=(w+1) mod NUM_REQ, abort to IDLE without sending the remaining bytes.
- WAIT_LO:
  - tx_busy=0 and byte_idx<3: byte_idx+1, go to SEND.
  - tx_busy=0 and byte_idx==3: frame_active=0, rr_ptr=(w+1) mod NUM_REQ, go to IDLE.
- Arbitration timing:
  - Earliest re-arbitration is the cycle after leaving WAIT_LO.
  - req_valid is sampled only in IDLE; a requester deasserting before its ack loses its place without side effects.
- Latency: grant cycle to first tx_start is 1 cycle when tx_busy=0.
- err_timeout:
  - err_clr=1 clears it on the next edge.
  - A timeout and err_clr in the same cycle leaves it set (set wins).
- tx_data holds its last value outside SEND.
- Wrap-around: rr_ptr=NUM_REQ-1 followed by a grant wraps rr_ptr to 0.
- Fairness: with all requesters valid continuously, grants rotate 0,1,2,3,0…

Test Plan:
- Single request: reset, req_valid=4'b0100, req_data[23:16]=8'h3C, transmitter model busy for 20 cycles per byte → one req_ack[2] pulse; bytes A5,02,3C,9B on tx_data at four tx_start pulses; frame_active falls after the 4th busy fall; cur_src=2.
- Fairness: req_valid=4'b1111 held, distinct data per requester → frame order 0,1,2,3,0; each requester acked exactly once per rotation.
- Starting busy: tx_busy=1 at the grant and held for 10 cycles → tx_start withheld until tx_busy=0, then 1 cycle later; no byte lost.
- Timeout: transmitter model never raises busy → err_timeout=1 exactly 16 cycles after the first tx_start; state returns to IDLE; next requester served. err_clr=1 clears it; err_clr in the timeout cycle leaves it 1.
- Reset mid-frame: assert rst_n=0 during the byte 2 WAIT_LO → next edge all outputs 0, rr_ptr=0; after release with tx_busy still high, the new frame's first tx_start waits for busy=0.
